// File: rtl/display_mode_sequencer.sv
// rtl/display_mode_sequencer.sv - frame-synchronous display mode scheduler for the HDMI compositor
module display_mode_sequencer #(
  parameter int FRAMES_PER_MODE = 120,
  parameter int CNT_W           = 8
) (
  input  logic             pixel_clk,
  input  logic             rst,
  input  logic             fsync,
  input  logic             vblank,
  input  logic             auto_en,
  input  logic             req_valid,
  input  logic [1:0]       req_mode,
  output logic             req_ready,
  output logic [1:0]       mode,
  output logic             enable_image,
  output logic             enable_text,
  output logic [1:0]       solid_sel,
  output logic             mode_change,
  output logic             mode_valid,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  // Last count value of a mode; compared at full CNT_W width so FRAMES_PER_MODE=1 advances every frame.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_MODE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [1:0]       pend_mode_q, pend_mode_d;
  logic             en_img_q, en_img_d;
  logic             en_txt_q, en_txt_d;
  logic [1:0]       solid_q, solid_d;
  logic             mode_change_q, mode_change_d;
  logic             req_ready_q, req_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             do_apply;
  logic [1:0]       apply_mode;
  logic             handshake;

  assign handshake = req_valid && req_ready_q;

  // Next-state and registered-output logic; an "apply" loads a new mode at a frame boundary.
  always_comb begin
    state_d       = state_q;
    pend_mode_d   = pend_mode_q;
    cnt_d         = cnt_q;
    mode_change_d = 1'b0;
    do_apply      = 1'b0;
    apply_mode    = mode_q;

    unique case (state_q)
      ST_WAIT: begin
        // First frame boundary only arms the sequencer; no count and no advance.
        if (fsync) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // A request outranks a coincident fsync; that fsync is neither counted nor used to advance.
        if (handshake) begin
          pend_mode_d = req_mode;
          state_d     = ST_PEND;
        end else if (fsync && auto_en) begin
          if (cnt_q == CNT_LAST) begin
            do_apply   = 1'b1;
            apply_mode = mode_q + 2'd1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else if (fsync) begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      ST_PEND: begin
        // Auto-advance is suppressed here; the latched request lands on the next boundary.
        if (fsync) begin
          do_apply   = 1'b1;
          apply_mode = pend_mode_q;
          state_d    = ST_RUN;
        end
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase

    mode_d   = mode_q;
    en_img_d = en_img_q;
    en_txt_d = en_txt_q;
    solid_d  = solid_q;
    if (do_apply) begin
      mode_d        = apply_mode;
      en_img_d      = (apply_mode == 2'd0) || (apply_mode == 2'd1);
      en_txt_d      = (apply_mode == 2'd0) || (apply_mode == 2'd2);
      cnt_d         = '0;
      mode_change_d = 1'b1;
      // Each fresh entry into solid mode steps the colour R->G->B->R; staying in mode 3 keeps it.
      if ((apply_mode == 2'd3) && (mode_q != 2'd3)) begin
        solid_d = (solid_q == 2'd2) ? 2'd0 : solid_q + 2'd1;
      end
    end

    req_ready_d = (state_d == ST_RUN);
  end

  // State and output registers with synchronous reset; reset drops any pending request.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q       <= ST_WAIT;
      mode_q        <= 2'd0;
      pend_mode_q   <= 2'd0;
      en_img_q      <= 1'b1;
      en_txt_q      <= 1'b1;
      solid_q       <= 2'd0;
      mode_change_q <= 1'b0;
      req_ready_q   <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      pend_mode_q   <= pend_mode_d;
      en_img_q      <= en_img_d;
      en_txt_q      <= en_txt_d;
      solid_q       <= solid_d;
      mode_change_q <= mode_change_d;
      req_ready_q   <= req_ready_d;
      cnt_q         <= cnt_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign mode         = mode_q;
  assign enable_image = en_img_q;
  assign enable_text  = en_txt_q;
  assign solid_sel    = solid_q;
  assign mode_change  = mode_change_q;
  assign frame_cnt    = cnt_q;
  // Status flag: mode is settled and the frame is in its active region.
  assign mode_valid   = (state_q == ST_RUN) && !vblank;

endmodule

// File: tb/tb_display_mode_sequencer.sv
// tb/tb_display_mode_sequencer.sv - directed self-checking bench for display_mode_sequencer
module tb_display_mode_sequencer;

  logic       clk;
  logic       rst;
  logic       fsync;
  logic       vblank;
  logic       auto_en;
  logic       req_valid;
  logic [1:0] req_mode;
  logic       req_ready;
  logic [1:0] mode;
  logic       enable_image;
  logic       enable_text;
  logic [1:0] solid_sel;
  logic       mode_change;
  logic       mode_valid;
  logic [7:0] frame_cnt;

  int checks;
  int errors;
  int mc_count;

  display_mode_sequencer #(
    .FRAMES_PER_MODE(3),
    .CNT_W(8)
  ) dut (
    .pixel_clk(clk),
    .rst(rst),
    .fsync(fsync),
    .vblank(vblank),
    .auto_en(auto_en),
    .req_valid(req_valid),
    .req_mode(req_mode),
    .req_ready(req_ready),
    .mode(mode),
    .enable_image(enable_image),
    .enable_text(enable_text),
    .solid_sel(solid_sel),
    .mode_change(mode_change),
    .mode_valid(mode_valid),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) mc_count = 0;
    else if (mode_change === 1'b1) mc_count = mc_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_fsync();
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode got %0d want 0", mode); end
    checks++; if (enable_image !== 1'b1 || enable_text !== 1'b1) begin errors++; $display("FAIL reset_enables got %b%b want 11", enable_image, enable_text); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", req_ready); end
    checks++; if (solid_sel !== 2'd0 || frame_cnt !== 8'd0 || mode_change !== 1'b0 || mode_valid !== 1'b0) begin
      errors++; $display("FAIL reset_misc got sel=%0d cnt=%0d mc=%b mv=%b want 0 0 0 0", solid_sel, frame_cnt, mode_change, mode_valid);
    end
    rst = 1'b0;
    tick();
    pulse_fsync();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL first_fsync_ready got %b want 1", req_ready); end
    checks++; if (frame_cnt !== 8'd0 || mode !== 2'd0) begin errors++; $display("FAIL first_fsync_cnt got cnt=%0d mode=%0d want 0 0", frame_cnt, mode); end
    checks++; if (mode_valid !== 1'b1) begin errors++; $display("FAIL mode_valid_run got %b want 1", mode_valid); end
    vblank = 1'b1;
    #1;
    checks++; if (mode_valid !== 1'b0) begin errors++; $display("FAIL mode_valid_vblank got %b want 0", mode_valid); end
    vblank = 1'b0;
  endtask

  task automatic test_auto();
    int mc0;
    mc0 = mc_count;
    repeat (2) pulse_fsync();
    checks++; if (mode !== 2'd0 || frame_cnt !== 8'd2) begin errors++; $display("FAIL auto_pre got mode=%0d cnt=%0d want 0 2", mode, frame_cnt); end
    pulse_fsync();
    checks++; if (mode !== 2'd1 || frame_cnt !== 8'd0) begin errors++; $display("FAIL auto_adv1 got mode=%0d cnt=%0d want 1 0", mode, frame_cnt); end
    checks++; if (mc_count - mc0 != 1) begin errors++; $display("FAIL auto_pulses got %0d want 1", mc_count - mc0); end
    checks++; if (enable_image !== 1'b1 || enable_text !== 1'b0) begin errors++; $display("FAIL auto_en_m1 got %b%b want 10", enable_image, enable_text); end
    repeat (3) pulse_fsync();
    checks++; if (mode !== 2'd2 || enable_image !== 1'b0 || enable_text !== 1'b1) begin errors++; $display("FAIL auto_m2 got mode=%0d en=%b%b want 2 01", mode, enable_image, enable_text); end
    repeat (3) pulse_fsync();
    checks++; if (mode !== 2'd3 || solid_sel !== 2'd1 || enable_image !== 1'b0 || enable_text !== 1'b0) begin
      errors++; $display("FAIL auto_m3 got mode=%0d sel=%0d en=%b%b want 3 1 00", mode, solid_sel, enable_image, enable_text);
    end
    repeat (3) pulse_fsync();
    checks++; if (mode !== 2'd0 || solid_sel !== 2'd1 || enable_image !== 1'b1 || enable_text !== 1'b1) begin
      errors++; $display("FAIL auto_wrap got mode=%0d sel=%0d en=%b%b want 0 1 11", mode, solid_sel, enable_image, enable_text);
    end
    checks++; if (mc_count - mc0 != 4) begin errors++; $display("FAIL auto_total_pulses got %0d want 4", mc_count - mc0); end
  endtask

  task automatic test_manual();
    req_valid = 1'b1;
    req_mode  = 2'd2;
    tick();
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL manual_ready_low got %b want 0", req_ready); end
    repeat (3) tick();
    checks++; if (req_ready !== 1'b0 || mode !== 2'd0) begin errors++; $display("FAIL manual_pend got ready=%b mode=%0d want 0 0", req_ready, mode); end
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    checks++; if (mode !== 2'd2 || enable_image !== 1'b0 || enable_text !== 1'b1 || frame_cnt !== 8'd0) begin
      errors++; $display("FAIL manual_apply got mode=%0d en=%b%b cnt=%0d want 2 01 0", mode, enable_image, enable_text, frame_cnt);
    end
    checks++; if (mode_change !== 1'b1 || req_ready !== 1'b1) begin errors++; $display("FAIL manual_pulse got mc=%b ready=%b want 1 1", mode_change, req_ready); end
    tick();
    checks++; if (mode_change !== 1'b0) begin errors++; $display("FAIL manual_pulse_width got %b want 0", mode_change); end
    tick();
  endtask

  task automatic test_collision();
    repeat (2) pulse_fsync();
    checks++; if (frame_cnt !== 8'd2 || mode !== 2'd2) begin errors++; $display("FAIL coll_pre got cnt=%0d mode=%0d want 2 2", frame_cnt, mode); end
    fsync     = 1'b1;
    req_valid = 1'b1;
    req_mode  = 2'd3;
    tick();
    fsync     = 1'b0;
    req_valid = 1'b0;
    checks++; if (mode !== 2'd2 || frame_cnt !== 8'd2 || mode_change !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL coll_no_adv got mode=%0d cnt=%0d mc=%b ready=%b want 2 2 0 0", mode, frame_cnt, mode_change, req_ready);
    end
    tick();
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    checks++; if (mode !== 2'd3 || solid_sel !== 2'd2 || frame_cnt !== 8'd0) begin
      errors++; $display("FAIL coll_apply got mode=%0d sel=%0d cnt=%0d want 3 2 0", mode, solid_sel, frame_cnt);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1;
    req_mode  = 2'd3;
    tick();
    req_valid = 1'b0;
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    checks++; if (mode !== 2'd3 || solid_sel !== 2'd2 || mode_change !== 1'b1) begin
      errors++; $display("FAIL m3_to_m3 got mode=%0d sel=%0d mc=%b want 3 2 1", mode, solid_sel, mode_change);
    end
    tick();
  endtask

  task automatic test_hold();
    int mc0;
    mc0 = mc_count;
    auto_en = 1'b0;
    repeat (300) pulse_fsync();
    checks++; if (mode !== 2'd3 || frame_cnt !== 8'd255) begin errors++; $display("FAIL hold got mode=%0d cnt=%0d want 3 255", mode, frame_cnt); end
    checks++; if (mc_count != mc0) begin errors++; $display("FAIL hold_pulses got %0d want 0", mc_count - mc0); end
    auto_en = 1'b1;
  endtask

  task automatic test_reset_in_pend();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pulse_fsync();
    req_valid = 1'b1;
    req_mode  = 2'd1;
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (mode !== 2'd0 || req_ready !== 1'b0) begin errors++; $display("FAIL rstpend_state got mode=%0d ready=%b want 0 0", mode, req_ready); end
    pulse_fsync();
    checks++; if (mode !== 2'd0 || req_ready !== 1'b1 || frame_cnt !== 8'd0) begin
      errors++; $display("FAIL rstpend_wait_exit got mode=%0d ready=%b cnt=%0d want 0 1 0", mode, req_ready, frame_cnt);
    end
    pulse_fsync();
    checks++; if (mode !== 2'd0 || frame_cnt !== 8'd1 || mc_count != 0) begin
      errors++; $display("FAIL rstpend_discard got mode=%0d cnt=%0d pulses=%0d want 0 1 0", mode, frame_cnt, mc_count);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    mc_count  = 0;
    rst       = 1'b1;
    fsync     = 1'b0;
    vblank    = 1'b0;
    auto_en   = 1'b1;
    req_valid = 1'b0;
    req_mode  = 2'd0;
    test_reset();
    test_auto();
    test_manual();
    test_collision();
    test_back_to_back();
    test_hold();
    test_reset_in_pend();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
